// File: rtl/williams_video_timing.sv
// Video timing stage behind williams_soc: pixel/line counters, blanking windows,
// aligned RGB/sync/blank outputs, line-length measurement and sync-lock detection.
module williams_video_timing #(
    parameter int HB_START = 336,
    parameter int HB_END   = 40,
    parameter int VB_START = 246,
    parameter int VB_END   = 6,
    parameter int CNT_W    = 11
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic [7:0]       rgb_in,
    output logic             ce_pix,
    output logic             hblank,
    output logic             vblank,
    output logic             de,
    output logic             hs_out,
    output logic             vs_out,
    output logic [7:0]       rgb_out,
    output logic [CNT_W-1:0] pcnt,
    output logic [CNT_W-1:0] lcnt,
    output logic [CNT_W-1:0] line_len,
    output logic             sync_ok
);

    typedef enum logic [1:0] {ST_LOST, ST_LOCKING, ST_LOCKED} sync_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-2:0] HB_S    = HB_START[CNT_W-2:0];
    localparam logic [CNT_W-2:0] HB_E    = HB_END[CNT_W-2:0];
    localparam logic [CNT_W-1:0] VB_S    = VB_START[CNT_W-1:0];
    localparam logic [CNT_W-1:0] VB_E    = VB_END[CNT_W-1:0];

    logic             old_hs_q, old_vs_q;
    logic [CNT_W-1:0] pcnt_q, pcnt_d, lcnt_q, lcnt_d, len_q, ref_q;
    logic             hblank_q, vblank_q, de_q, hs_out_q, vs_out_q;
    logic [7:0]       rgb_q;
    sync_state_t      state_q;
    logic             one_match_q, miss_q, vs_seen_q, sync_ok_q;
    logic             hs_rise, vs_rise, lost_ev, blank;

    always_comb begin
        hs_rise = hs_in & ~old_hs_q;
        vs_rise = hs_rise & vs_in & ~old_vs_q;

        pcnt_d = pcnt_q;
        if (hs_rise)
            pcnt_d = '0;
        else if (pcnt_q != CNT_MAX)
            pcnt_d = pcnt_q + 1'b1;

        lcnt_d = lcnt_q;
        if (vs_rise)
            lcnt_d = '0;
        else if (hs_rise && lcnt_q != CNT_MAX)
            lcnt_d = lcnt_q + 1'b1;

        // Judged on next-state values so an hs_rise that resets pcnt rescues the line.
        lost_ev = (pcnt_d == CNT_MAX) | (lcnt_d == CNT_MAX);
        blank   = hblank_q | vblank_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            old_hs_q <= 1'b0;
            old_vs_q <= 1'b0;
            pcnt_q   <= '0;
            lcnt_q   <= '0;
            len_q    <= '0;
        end else begin
            old_hs_q <= hs_in;
            pcnt_q   <= pcnt_d;
            lcnt_q   <= lcnt_d;
            if (hs_rise) begin
                old_vs_q <= vs_in;
                len_q    <= pcnt_q;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            de_q     <= 1'b0;
            hs_out_q <= 1'b0;
            vs_out_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            if (pcnt_q[CNT_W-1:1] == HB_S)
                hblank_q <= 1'b1;
            else if (pcnt_q[CNT_W-1:1] == HB_E)
                hblank_q <= 1'b0;
            if (lcnt_q == VB_S)
                vblank_q <= 1'b1;
            else if (lcnt_q == VB_E)
                vblank_q <= 1'b0;
            if (pcnt_q[0]) begin
                rgb_q    <= blank ? 8'h00 : rgb_in;
                de_q     <= ~blank;
                hs_out_q <= hs_in;
                vs_out_q <= vs_in;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOST;
            one_match_q <= 1'b0;
            miss_q      <= 1'b0;
            vs_seen_q   <= 1'b0;
            ref_q       <= '0;
            sync_ok_q   <= 1'b0;
        end else if (lost_ev) begin
            state_q     <= ST_LOST;
            one_match_q <= 1'b0;
            miss_q      <= 1'b0;
            vs_seen_q   <= 1'b0;
            sync_ok_q   <= 1'b0;
        end else begin
            if (vs_rise)
                vs_seen_q <= 1'b1;
            if (hs_rise) begin
                case (state_q)
                    ST_LOST: begin
                        state_q     <= ST_LOCKING;
                        one_match_q <= 1'b0;
                    end
                    ST_LOCKING: begin
                        if (pcnt_q != len_q) begin
                            one_match_q <= 1'b0;
                        end else if (one_match_q && (vs_seen_q || vs_rise)) begin
                            state_q   <= ST_LOCKED;
                            sync_ok_q <= 1'b1;
                            ref_q     <= pcnt_q;
                            miss_q    <= 1'b0;
                        end else begin
                            one_match_q <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        // Compared against the locked length so one odd line costs only one miss.
                        if (pcnt_q == ref_q) begin
                            miss_q <= 1'b0;
                        end else if (miss_q) begin
                            state_q     <= ST_LOST;
                            sync_ok_q   <= 1'b0;
                            vs_seen_q   <= 1'b0;
                            one_match_q <= 1'b0;
                            miss_q      <= 1'b0;
                        end else begin
                            miss_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_LOST;
                endcase
            end
        end
    end

    assign ce_pix   = pcnt_q[0];
    assign hblank   = hblank_q;
    assign vblank   = vblank_q;
    assign de       = de_q;
    assign hs_out   = hs_out_q;
    assign vs_out   = vs_out_q;
    assign rgb_out  = rgb_q;
    assign pcnt     = pcnt_q;
    assign lcnt     = lcnt_q;
    assign line_len = len_q;
    assign sync_ok  = sync_ok_q;

endmodule

// File: doc/williams_video_timing.md
# williams_video_timing

Video timing stage directly downstream of `williams_soc`. It consumes the raw sync and 8-bit RGB (3-3-2) from the SoC, derives the pixel clock enable, horizontal/vertical counters and blanking windows, and registers aligned RGB/sync/blank outputs for `arcade_video` and `screen_rotate`. It also measures line length and flags loss of sync so the top level can force blank during ROM download or a core swap.

## Interface
Parameters:
- `HB_START`, 336, pixel index (`pcnt[10:1]`) at which hblank asserts
- `HB_END`, 40, pixel index at which hblank deasserts
- `VB_START`, 246, line index at which vblank asserts
- `VB_END`, 6, line index at which vblank deasserts
- `CNT_W`, 11, width of the pixel and line counters

Ports:
- `clk_sys` in 1: system clock; one clock domain, the only one
- `reset_n` in 1: reset, asynchronous, active-low
- `hs_in` in 1: SoC horizontal sync, active-high, synchronous to `clk_sys`
- `vs_in` in 1: SoC vertical sync, active-high
- `rgb_in` in 8: {r[2:0], g[2:0], b[1:0]} from SoC
- `ce_pix` out 1: pixel enable, one cycle in two
- `hblank` out 1: horizontal blank
- `vblank` out 1: vertical blank
- `de` out 1: `~(hblank|vblank)`, registered
- `hs_out` out 1: `hs_in` delayed to align with `rgb_out`
- `vs_out` out 1: `vs_in` delayed to align with `rgb_out`
- `rgb_out` out 8: registered RGB, forced to 0 while blanked
- `pcnt` out CNT_W: pixel counter in clocks since last hs rising edge
- `lcnt` out CNT_W: line counter since last vs-qualified line start
- `line_len` out CNT_W: `pcnt` value captured at last hs rising edge
- `sync_ok` out 1: stable timing detected

## Operation
- `old_hs` register holds `hs_in` of the previous cycle. `hs_rise = hs_in & ~old_hs`.
- `pcnt`: increments every cycle and saturates at all-ones. On `hs_rise`, `pcnt` <= 0 and `line_len` <= current `pcnt`.
- `lcnt`: on `hs_rise`, increments with saturation at all-ones. `old_vs` updates only on `hs_rise`. If `vs_in & ~old_vs` at that `hs_rise`, `lcnt` <= 0; this takes priority over the increment.
- `ce_pix` = `pcnt[0]`.
- `hblank`: set when `pcnt[10:1]==HB_START`, cleared when `==HB_END`. Both comparisons are evaluated every clock.
- `vblank`: set when `lcnt==VB_START`, cleared when `==VB_END`.
- Output stage updates on cycles where `ce_pix` = 1:
  - `rgb_out` <= blank ? 0 : `rgb_in`
  - `hs_out` <= `hs_in`, `vs_out` <= `vs_in`
  - `de` <= ~blank, where blank is the current `hblank|vblank`
- `sync_ok` state machine, states LOST, LOCKING, LOCKED:
  - LOST→LOCKING on `hs_rise`.
  - LOCKING→LOCKED after 2 consecutive `hs_rise` whose captured `pcnt` equals the previous `line_len`, and `lcnt` has been reset by vs at least once since LOST.
  - A mismatch in LOCKING restarts the count.
  - Any state→LOST when `pcnt` saturates (hs missing) or `lcnt` saturates (vs missing).
  - In LOCKED, a single length mismatch is tolerated; two consecutive mismatches go to LOST.
  - `sync_ok` = (state==LOCKED).

## Timing
- Reset values: `pcnt`, `lcnt`, `line_len` = 0; `old_hs`, `old_vs` = 0; `hblank`, `vblank` = 1; `de`, `hs_out`, `vs_out` = 0; `rgb_out` = 0; state LOST; `sync_ok` = 0.
- `hs_rise` is detected in the first cycle `hs_in`=1 after a cycle at 0. `pcnt` reads 0 in the next cycle.
- Blank flags change one cycle after the counter reaches the compare value.
- `rgb_out`/`de`/syncs have 1–2 cycle latency from `rgb_in`, always updated on the same `ce_pix` edge, so they stay mutually aligned.
- If START==END for a window, set wins and the flag stays asserted.
- Asserting `reset_n` mid-line returns all outputs to reset values immediately (async). After release, the counters restart from 0 with no glitch on `ce_pix`.
- `hs_rise` in the same cycle as `pcnt` saturation: the reset to 0 wins and the state stays out of LOST.

## Test plan
- Nominal 1024-clock lines with `hs_in` high 64 clocks, vs every 260 lines → `line_len`=1023, `hblank` high for `pcnt[10:1]` in 336..39 (wrapping), `vblank` high for `lcnt` 246..5, `sync_ok` high by the 3rd line after the first vs.
- `rgb_in`=8'hFF constant → `rgb_out`=0 during any blank and 8'hFF otherwise; `de` equals ~(`hblank|vblank`), sampled on `ce_pix`.
- Stop `hs_in` → `pcnt` saturates at 2047, `sync_ok` drops that cycle, `lcnt` holds.
- One line shortened to 1000 clocks while LOCKED → `sync_ok` stays 1; two consecutive short lines → `sync_ok`=0, then relocks after 2 matching lines.
- `reset_n` pulsed low at `pcnt`=500 → all outputs at reset values within the same cycle; `hblank`/`vblank`=1 until the counters pass the END values again.
- vs rising sampled at `hs_rise` while `lcnt`=2047 (saturated) → `lcnt`=0 on the next cycle, state LOCKING.
